quick_attack_sequencer: RTL

- Upstream control FSM for the Pikachu quick-attack animation block.
- On a start request from the battle controller, it runs a per-frame loop: erase the old sprite, step the position, redraw Pikachu, then wait for the frame tick.
- Drives the animation block's enable_animate, enable_p_qa and enable_draw_pika, plus an erase-drawer enable and the VGA plot/source-select.
- Ends the attack once the animation block signals done_quick_attack.

---
 rtl/quick_attack_sequencer_if.sv | 49 ++++
 rtl/quick_attack_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/quick_attack_sequencer_if.sv
// quick_attack_sequencer_if
// Purpose: bundles the request/done handshakes and the drawing-control
//          outputs of the quick-attack sequencer into one interface.
// Signals:
//   start_qa          request from the battle menu FSM (single cycle)
//   done_erase        background-erase drawer finished (level)
//   done_pikachu      sprite drawer finished (level)
//   done_animate      frame tick (one-cycle pulse)
//   done_quick_attack attack-length counter terminal count (may be 1 cycle)
//   enable_animate    frame timer / attack counter enable
//   enable_p_qa       position stepper enable
//   enable_draw_pika  sprite drawer enable
//   enable_erase      erase drawer enable
//   plot              VGA write enable
//   colour_sel        pixel source select: 0 = erase, 1 = Pikachu
//   busy              sequencer not idle
//   qa_finished       one-cycle completion pulse
//   frames_done       frames completed in the current attack
//   qa_error          watchdog fired, sticky until the next start
// Modports: master = battle controller / drawers side, slave = sequencer.
interface quick_attack_sequencer_if;
    logic       start_qa;
    logic       done_erase;
    logic       done_pikachu;
    logic       done_animate;
    logic       done_quick_attack;
    logic       enable_animate;
    logic       enable_p_qa;
    logic       enable_draw_pika;
    logic       enable_erase;
    logic       plot;
    logic       colour_sel;
    logic       busy;
    logic       qa_finished;
    logic [5:0] frames_done;
    logic       qa_error;

    modport master (
        output start_qa, done_erase, done_pikachu, done_animate, done_quick_attack,
        input  enable_animate, enable_p_qa, enable_draw_pika, enable_erase,
               plot, colour_sel, busy, qa_finished, frames_done, qa_error
    );

    modport slave (
        input  start_qa, done_erase, done_pikachu, done_animate, done_quick_attack,
        output enable_animate, enable_p_qa, enable_draw_pika, enable_erase,
               plot, colour_sel, busy, qa_finished, frames_done, qa_error
    );
endinterface

// File: rtl/quick_attack_sequencer.sv
// quick_attack_sequencer
// Purpose: control FSM for the Pikachu quick-attack animation. Per frame it
//          erases the old sprite, steps the position, redraws Pikachu and
//          waits for the frame tick; the attack ends once the attack-length
//          counter reports done_quick_attack.
// Ports:
//   clock      system clock
//   reset_all  asynchronous active-low reset
//   qa         quick_attack_sequencer_if.slave (handshakes and enables)
// Parameters:
//   MOVE_STEPS      cycles enable_p_qa is held per frame (1..15)
//   WATCHDOG_CYCLES per-state timeout, used only with the watchdog build
// Build option: define QA_WATCHDOG_EN to build the per-state watchdog;
//               otherwise qa_error is tied low.
module quick_attack_sequencer #(
    parameter int unsigned MOVE_STEPS      = 1,
    parameter logic [19:0] WATCHDOG_CYCLES = 20'hFFFFF
) (
    input  logic                    clock,
    input  logic                    reset_all,
    quick_attack_sequencer_if.slave qa
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ERASE      = 3'd1,
        MOVE       = 3'd2,
        DRAW       = 3'd3,
        WAIT_FRAME = 3'd4,
        FINISH     = 3'd5
    } state_t;

    localparam logic [3:0] STEP_LAST  = 4'(MOVE_STEPS - 1);
    localparam logic [5:0] FRAMES_MAX = 6'd63;

    state_t     state_r;
    state_t     next_state_s;
    logic [3:0] step_cnt_r;
    logic [5:0] frames_done_r;
    logic       seen_done_r;
    logic       wd_timeout_s;
    logic       start_accept_s;
    logic       frame_tick_s;

    logic enable_animate_s, enable_p_qa_s, enable_draw_pika_s, enable_erase_s;
    logic plot_s, colour_sel_s, busy_s, qa_finished_s;
    logic enable_animate_r, enable_p_qa_r, enable_draw_pika_r, enable_erase_r;
    logic plot_r, colour_sel_r, busy_r, qa_finished_r;

    assign start_accept_s = (state_r == IDLE) && qa.start_qa;
    assign frame_tick_s   = (state_r == WAIT_FRAME) && qa.done_animate;

`ifdef QA_WATCHDOG_EN
    localparam logic [19:0] WD_LAST = WATCHDOG_CYCLES - 20'd1;
    logic [19:0] wd_cnt_r;
    logic        qa_error_r;

    // Watchdog counter: restarts on every state change, saturates otherwise
    always_ff @(posedge clock or negedge reset_all) begin
        if (!reset_all) begin
            wd_cnt_r <= 20'd0;
        end else if (next_state_s != state_r) begin
            wd_cnt_r <= 20'd0;
        end else if (wd_cnt_r != 20'hFFFFF) begin
            wd_cnt_r <= wd_cnt_r + 20'd1;
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    // Timeout only in states that wait on an external done; the compare
    // against WD_LAST makes the state last exactly WATCHDOG_CYCLES cycles
    always_comb begin
        wd_timeout_s = 1'b0;
        if (((state_r == ERASE) || (state_r == DRAW) || (state_r == WAIT_FRAME))
            && (wd_cnt_r == WD_LAST)) begin
            wd_timeout_s = 1'b1;
        end else begin
            wd_timeout_s = 1'b0;
        end
    end

    // Sticky error flag, cleared only by an accepted start
    always_ff @(posedge clock or negedge reset_all) begin
        if (!reset_all) begin
            qa_error_r <= 1'b0;
        end else if (start_accept_s) begin
            qa_error_r <= 1'b0;
        end else if (wd_timeout_s) begin
            qa_error_r <= 1'b1;
        end else begin
            qa_error_r <= qa_error_r;
        end
    end

    assign qa.qa_error = qa_error_r;
`else
    // Keeps the timeout parameter referenced when no watchdog is built
    logic unused_wd_s;
    assign unused_wd_s  = ^WATCHDOG_CYCLES;
    assign wd_timeout_s = 1'b0;
    assign qa.qa_error  = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (qa.start_qa) next_state_s = ERASE;
                else             next_state_s = IDLE;
            end
            ERASE: begin
                if (wd_timeout_s)       next_state_s = FINISH;
                else if (qa.done_erase) next_state_s = MOVE;
                else                    next_state_s = ERASE;
            end
            MOVE: begin
                if (step_cnt_r == STEP_LAST) next_state_s = DRAW;
                else                         next_state_s = MOVE;
            end
            DRAW: begin
                // A frame tick arriving together with done_pikachu is dropped
                if (wd_timeout_s)         next_state_s = FINISH;
                else if (qa.done_pikachu) next_state_s = WAIT_FRAME;
                else                      next_state_s = DRAW;
            end
            WAIT_FRAME: begin
                // done_quick_attack may already have come and gone, hence seen_done_r
                if (wd_timeout_s) begin
                    next_state_s = FINISH;
                end else if (qa.done_animate) begin
                    if (seen_done_r || qa.done_quick_attack) next_state_s = FINISH;
                    else                                     next_state_s = ERASE;
                end else begin
                    next_state_s = WAIT_FRAME;
                end
            end
            FINISH:  next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode from the next state so the registered enables are
    // valid in the first cycle of each state
    always_comb begin
        enable_animate_s   = 1'b0;
        enable_p_qa_s      = 1'b0;
        enable_draw_pika_s = 1'b0;
        enable_erase_s     = 1'b0;
        plot_s             = 1'b0;
        colour_sel_s       = 1'b0;
        qa_finished_s      = 1'b0;
        busy_s             = (next_state_s != IDLE);
        case (next_state_s)
            ERASE: begin
                enable_animate_s = 1'b1;
                enable_erase_s   = 1'b1;
                plot_s           = 1'b1;
            end
            MOVE: begin
                enable_animate_s = 1'b1;
                enable_p_qa_s    = 1'b1;
            end
            DRAW: begin
                enable_animate_s   = 1'b1;
                enable_draw_pika_s = 1'b1;
                plot_s             = 1'b1;
                colour_sel_s       = 1'b1;
            end
            WAIT_FRAME: enable_animate_s = 1'b1;
            FINISH:     qa_finished_s    = 1'b1;
            IDLE:       busy_s           = 1'b0;
            default:    busy_s           = 1'b0;
        endcase
    end

    // State, step counter, frame counter, done latch and output registers
    always_ff @(posedge clock or negedge reset_all) begin
        if (!reset_all) begin
            state_r            <= IDLE;
            step_cnt_r         <= 4'd0;
            frames_done_r      <= 6'd0;
            seen_done_r        <= 1'b0;
            enable_animate_r   <= 1'b0;
            enable_p_qa_r      <= 1'b0;
            enable_draw_pika_r <= 1'b0;
            enable_erase_r     <= 1'b0;
            plot_r             <= 1'b0;
            colour_sel_r       <= 1'b0;
            busy_r             <= 1'b0;
            qa_finished_r      <= 1'b0;
        end else begin
            state_r <= next_state_s;

            if ((state_r == MOVE) && (next_state_s == MOVE)) step_cnt_r <= step_cnt_r + 4'd1;
            else                                             step_cnt_r <= 4'd0;

            if (start_accept_s)                                     frames_done_r <= 6'd0;
            else if (frame_tick_s && (frames_done_r != FRAMES_MAX)) frames_done_r <= frames_done_r + 6'd1;
            else                                                    frames_done_r <= frames_done_r;

            if (start_accept_s)                                        seen_done_r <= 1'b0;
            else if ((state_r != IDLE) && qa.done_quick_attack)        seen_done_r <= 1'b1;
            else                                                       seen_done_r <= seen_done_r;

            enable_animate_r   <= enable_animate_s;
            enable_p_qa_r      <= enable_p_qa_s;
            enable_draw_pika_r <= enable_draw_pika_s;
            enable_erase_r     <= enable_erase_s;
            plot_r             <= plot_s;
            colour_sel_r       <= colour_sel_s;
            busy_r             <= busy_s;
            qa_finished_r      <= qa_finished_s;
        end
    end

    assign qa.enable_animate   = enable_animate_r;
    assign qa.enable_p_qa      = enable_p_qa_r;
    assign qa.enable_draw_pika = enable_draw_pika_r;
    assign qa.enable_erase     = enable_erase_r;
    assign qa.plot             = plot_r;
    assign qa.colour_sel       = colour_sel_r;
    assign qa.busy             = busy_r;
    assign qa.qa_finished      = qa_finished_r;
    assign qa.frames_done      = frames_done_r;

endmodule
